// File: rtl/div_check_seq.sv
// Digit-serial BCD divisibility checker (divide-by-11 or divide-by-3).
// Walks the operand MSD-first, one digit per clock, and hands off a registered result.
module div_check_seq #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_digits,
    input  logic              in_div11,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_div,
    output logic [3:0]        out_rem,
    output logic              out_err,
    output logic              busy,
    output logic [7:0]        pass_cnt,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready and out_valid are pure state decodes, so neither depends on the opposite side.

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [4*NDIG-1:0] digits;
    logic              div11;
    logic [IW-1:0]     idx;
    logic [3:0]        res;
    logic              err;

    logic [3:0]        d;
    logic [6:0]        acc;
    logic [3:0]        nxt_res;
    logic              nxt_err;

    // Residue step: (10*res + d) mod M; acc tops out at 10*10+15 = 115.
    always_comb begin
        d       = digits[{idx, 2'b00} +: 4];
        acc     = 7'd10 * {3'b000, res} + {3'b000, d};
        nxt_res = div11 ? 4'(acc % 7'd11) : 4'(acc % 7'd3);
        nxt_err = err | (d > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            digits   <= '0;
            div11    <= 1'b0;
            idx      <= '0;
            res      <= '0;
            err      <= 1'b0;
            out_div  <= 1'b0;
            out_rem  <= '0;
            out_err  <= 1'b0;
            pass_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        digits <= in_digits;
                        div11  <= in_div11;
                        res    <= '0;
                        err    <= 1'b0;
                        idx    <= IW'(NDIG - 1);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    res <= nxt_res;
                    err <= nxt_err;
                    if (idx == '0) begin
                        out_div <= (nxt_res == 4'd0) && !nxt_err;
                        out_rem <= nxt_res;
                        out_err <= nxt_err;
                        state   <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (out_div) pass_cnt <= pass_cnt + 8'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_div_check_seq.sv
// Bench for div_check_seq: directed operands checked against an arithmetic model
// (integer value of the digit string mod M) and a few hand-computed literals.
module tb_div_check_seq;

    localparam int NDIG = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_digits;
    logic        in_div11;
    logic        out_valid;
    logic        out_ready;
    logic        out_div;
    logic [3:0]  out_rem;
    logic        out_err;
    logic        busy;
    logic [7:0]  pass_cnt;
    logic [1:0]  dbg_state;

    div_check_seq #(.NDIG(NDIG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_digits(in_digits), .in_div11(in_div11),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_div(out_div), .out_rem(out_rem), .out_err(out_err),
        .busy(busy), .pass_cnt(pass_cnt), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int exp_pass = 0;
    logic [5:0] exp_q[$];   // {div, rem[3:0], err}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: integer value of the digit string (digits > 9 taken at face value) mod M.
    function automatic logic [5:0] model(input logic [15:0] dg, input logic m11);
        int v;
        int r;
        bit er;
        logic [3:0] dd;
        v  = 0;
        er = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            dd = dg[4*i +: 4];
            v  = v * 10 + int'(dd);
            if (dd > 4'd9) er = 1'b1;
        end
        r = v % (m11 ? 11 : 3);
        return {(r == 0) && !er, 4'(r), er};
    endfunction

    // scoreboard: checks every cycle out of reset, and each handoff against the queue
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("pass_cnt", {24'd0, pass_cnt}, exp_pass % 256);
                check("in_ready_vs_busy", {31'd0, in_ready}, {31'd0, !busy});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_result: got out_valid=1 expected no result (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_div", {31'd0, out_div}, {31'd0, e[5]});
                        check("out_rem", {28'd0, out_rem}, {28'd0, e[4:1]});
                        check("out_err", {31'd0, out_err}, {31'd0, e[0]});
                        if (e[5]) exp_pass++;
                    end
                end
            end
        end
    end

    // driver: called at posedge+1; returns at posedge+1 after the handoff edge
    task automatic run_op(input logic [15:0] dg, input logic m11, input int hold, input bit pulse,
                          input bit use_lit, input logic l_div, input logic [3:0] l_rem, input logic l_err);
        int n;
        int c0;
        logic [5:0] snap;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(model(dg, m11));
        out_ready = (hold == 0);
        in_digits = dg;
        in_div11  = m11;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        in_valid  = 1'b0;
        in_digits = 16'($urandom);
        in_div11  = 1'($urandom_range(0, 1));
        if (pulse) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_digits = 16'h1111;
            @(posedge clk); #1;
            in_valid  = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!out_valid && n < 20);
        if (!out_valid) begin
            checks++;
            $display("FAIL out_valid_timeout: got 0 expected 1 within 20 cycles");
            return;
        end
        check("latency", cyc - c0, NDIG);
        if (hold > 0) begin
            snap = {out_div, out_rem, out_err};
            repeat (hold) begin
                @(negedge clk);
                check("bp_valid", {31'd0, out_valid}, 32'd1);
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_stable", {26'd0, out_div, out_rem, out_err}, {26'd0, snap});
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("valid_dropped", {31'd0, out_valid}, 32'd0);
        if (use_lit) begin
            check("lit_div", {31'd0, out_div}, {31'd0, l_div});
            check("lit_rem", {28'd0, out_rem}, {28'd0, l_rem});
            check("lit_err", {31'd0, out_err}, {31'd0, l_err});
        end
    endtask

    logic [15:0] wrap_dg[4] = '{16'h3234, 16'h8558, 16'h0000, 16'h9999};
    logic        wrap_m[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_digits = '0; in_div11 = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pass_cnt", {24'd0, pass_cnt}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h3235, 1'b0, 0, 0, 1, 1'b0, 4'd1, 1'b0);
        run_op(16'h3235, 1'b1, 0, 0, 1, 1'b0, 4'd1, 1'b0);
        run_op(16'h3234, 1'b0, 0, 0, 1, 1'b1, 4'd0, 1'b0);
        run_op(16'h3234, 1'b1, 0, 0, 1, 1'b1, 4'd0, 1'b0);
        run_op(16'h8558, 1'b1, 0, 0, 1, 1'b1, 4'd0, 1'b0);
        run_op(16'h8382, 1'b1, 0, 0, 1, 1'b1, 4'd0, 1'b0);
        check("pass_cnt_4", {24'd0, pass_cnt}, 32'd4);
        run_op(16'h9999, 1'b0, 0, 0, 1, 1'b1, 4'd0, 1'b0);
        run_op(16'h9899, 1'b1, 0, 0, 1, 1'b0, 4'd10, 1'b0);
        run_op(16'h0000, 1'b0, 0, 0, 1, 1'b1, 4'd0, 1'b0);
        run_op(16'h0000, 1'b1, 0, 0, 1, 1'b1, 4'd0, 1'b0);
        run_op(16'h3A35, 1'b0, 0, 0, 1, 1'b0, 4'd0, 1'b1);
        check("pass_cnt_after_err", {24'd0, pass_cnt}, 32'd7);

        // backpressure, then an in_valid pulse during RUN
        run_op(16'h1221, 1'b1, 5, 0, 1, 1'b1, 4'd0, 1'b0);
        run_op(16'h9899, 1'b1, 0, 1, 1, 1'b0, 4'd10, 1'b0);
        repeat (NDIG + 2) begin
            @(negedge clk);
            check("no_capture_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // reset during the second RUN cycle discards the operation
        in_digits = 16'h3234; in_div11 = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        exp_q.delete();
        exp_pass = 0;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_div", {31'd0, out_div}, 32'd0);
        check("mid_rst_out_rem", {28'd0, out_rem}, 32'd0);
        check("mid_rst_out_err", {31'd0, out_err}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_pass_cnt", {24'd0, pass_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h3234, 1'b1, 0, 0, 1, 1'b1, 4'd0, 1'b0);
        check("pass_cnt_after_rst", {24'd0, pass_cnt}, 32'd1);

        // 255 more divisible results: 256 in total since reset, counter wraps to 0
        for (int i = 0; i < 255; i++)
            run_op(wrap_dg[i % 4], wrap_m[i % 4], 0, 0, 0, 1'b0, 4'd0, 1'b0);
        check("pass_cnt_wrap", {24'd0, pass_cnt}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        checks++;
        $display("FAIL global_timeout: got no finish expected finish by 1ms");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
